// File: rtl/tex_spi_reader.sv
// Quad-output fast-read (0x6B) byte fetcher for the texture SPI flash; SCLK = i_clk/2.
// Optional single-entry byte cache under TEX_SPI_BYTE_CACHE_EN; without it every request goes to flash.
module tex_spi_reader #(
  parameter logic [7:0] CMD          = 8'h6B,
  parameter int         DUMMY_CYCLES = 8
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic [23:0] i_req_addr,
  output logic        o_req_ready,
  output logic        o_data_valid,
  output logic [7:0]  o_data,
  output logic        o_tex_csb,
  output logic        o_tex_sclk,
  output logic        o_tex_out0,
  output logic        o_tex_oeb,
  input  logic [3:0]  i_tex_in
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_DUMMY,
    S_DATA,
    S_DONE
  } state_t;

  state_t      state_q;
  logic        phase_q;
  logic [4:0]  cnt_q;
  logic [31:0] shreg_q;
  logic [3:0]  nib_q;
  logic        csb_q;
  logic        sclk_q;
  logic        out0_q;
  logic        oeb_q;
  logic        valid_q;
  logic [7:0]  data_q;
  logic        ready_q;

`ifdef TEX_SPI_BYTE_CACHE_EN
  logic        cache_vld_q;
  logic [23:0] cache_addr_q;
  logic [7:0]  cache_dat_q;
  logic [23:0] addr_q;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      phase_q <= 1'b0;
      cnt_q   <= 5'd0;
      shreg_q <= 32'd0;
      nib_q   <= 4'd0;
      csb_q   <= 1'b1;
      sclk_q  <= 1'b0;
      out0_q  <= 1'b0;
      oeb_q   <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= 8'd0;
      ready_q <= 1'b1;
`ifdef TEX_SPI_BYTE_CACHE_EN
      cache_vld_q  <= 1'b0;
      cache_addr_q <= 24'd0;
      cache_dat_q  <= 8'd0;
      addr_q       <= 24'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          valid_q <= 1'b0;
          if (i_req_valid) begin
            ready_q <= 1'b0;
`ifdef TEX_SPI_BYTE_CACHE_EN
            addr_q  <= i_req_addr;
            if (cache_vld_q && (cache_addr_q == i_req_addr)) begin
              state_q <= S_DONE;
              valid_q <= 1'b1;
              data_q  <= cache_dat_q;
            end else
`endif
            begin
              state_q <= S_CMD;
              shreg_q <= {CMD, i_req_addr};
              csb_q   <= 1'b0;
              out0_q  <= CMD[7];
              oeb_q   <= 1'b0;
              phase_q <= 1'b0;
              cnt_q   <= 5'd0;
            end
          end
        end
        S_DONE: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          if (!phase_q) begin
            phase_q <= 1'b1;
            sclk_q  <= 1'b1;
          end else begin
            // End of the high phase: advance to the next bit and present it on io0.
            phase_q <= 1'b0;
            sclk_q  <= 1'b0;
            cnt_q   <= cnt_q + 5'd1;
            shreg_q <= {shreg_q[30:0], 1'b0};
            out0_q  <= shreg_q[30];
            case (state_q)
              S_CMD: begin
                if (cnt_q == 5'd7) begin
                  state_q <= S_ADDR;
                  cnt_q   <= 5'd0;
                end
              end
              S_ADDR: begin
                if (cnt_q == 5'd23) begin
                  state_q <= S_DUMMY;
                  cnt_q   <= 5'd0;
                  oeb_q   <= 1'b1;
                  out0_q  <= 1'b0;
                end
              end
              S_DUMMY: begin
                out0_q <= 1'b0;
                if (cnt_q == 5'(DUMMY_CYCLES - 1)) begin
                  state_q <= S_DATA;
                  cnt_q   <= 5'd0;
                end
              end
              S_DATA: begin
                out0_q <= 1'b0;
                if (cnt_q == 5'd0) begin
                  nib_q <= i_tex_in;
                end else begin
                  data_q  <= {nib_q, i_tex_in};
                  valid_q <= 1'b1;
                  csb_q   <= 1'b1;
                  state_q <= S_DONE;
`ifdef TEX_SPI_BYTE_CACHE_EN
                  cache_vld_q  <= 1'b1;
                  cache_addr_q <= addr_q;
                  cache_dat_q  <= {nib_q, i_tex_in};
`endif
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign o_req_ready  = ready_q;
  assign o_data_valid = valid_q;
  assign o_data       = data_q;
  assign o_tex_csb    = csb_q;
  assign o_tex_sclk   = sclk_q;
  assign o_tex_out0   = out0_q;
  assign o_tex_oeb    = oeb_q;

endmodule

// File: tb/tb_tex_spi_reader.sv
// Directed bench for tex_spi_reader: behavioural quad-output flash plus a scoreboard of expected bytes/cycles.
module tb_tex_spi_reader;

  localparam int LAT = 2 * (8 + 24 + 8 + 2);  // cycles from first csb-low cycle to the valid cycle

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_req_valid = 1'b0;
  logic [23:0] i_req_addr = 24'd0;
  logic        o_req_ready;
  logic        o_data_valid;
  logic [7:0]  o_data;
  logic        o_tex_csb;
  logic        o_tex_sclk;
  logic        o_tex_out0;
  logic        o_tex_oeb;
  logic [3:0]  i_tex_in = 4'd0;

  tex_spi_reader dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .i_req_addr   (i_req_addr),
    .o_req_ready  (o_req_ready),
    .o_data_valid (o_data_valid),
    .o_data       (o_data),
    .o_tex_csb    (o_tex_csb),
    .o_tex_sclk   (o_tex_sclk),
    .o_tex_out0   (o_tex_out0),
    .o_tex_oeb    (o_tex_oeb),
    .i_tex_in     (i_tex_in)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] mem(input logic [23:0] a);
    case (a)
      24'h012345: mem = 8'hA5;
      24'h000010: mem = 8'h3C;
      24'h000011: mem = 8'hC3;
      24'h00ABCD: mem = 8'h5A;
      24'h00ABCE: mem = 8'h96;
      24'h000201: mem = 8'hE1;
      24'h000300: mem = 8'h7E;
      default:    mem = 8'h00;
    endcase
  endfunction

  // Flash model: shifts in cmd+addr on rising sclk, drives the two data nibbles after the dummy clocks.
  int          rises = 0;
  int          csb_falls = 0;
  logic [31:0] fsh = 32'd0;
  logic [7:0]  fcmd = 8'd0;
  logic [23:0] faddr = 24'd0;

  always @(negedge o_tex_csb) begin
    rises = 0;
    csb_falls++;
  end

  always @(posedge o_tex_sclk) begin
    logic [7:0] m;
    rises++;
    if (rises <= 32) begin
      chk("oeb_low_cmd_addr", {31'd0, o_tex_oeb}, 32'd0);
      fsh = {fsh[30:0], o_tex_out0};
      if (rises == 32) begin
        fcmd  = fsh[31:24];
        faddr = fsh[23:0];
      end
    end else if (rises <= 40) begin
      chk("oeb_high_dummy", {31'd0, o_tex_oeb}, 32'd1);
    end
    m = mem(faddr);
    if (rises == 41) i_tex_in = m[7:4];
    if (rises == 42) i_tex_in = m[3:0];
  end

  typedef struct {
    logic [7:0]  dat;
    int          vcyc;
    logic [23:0] addr;
    bit          hit;
    int          falls;
  } exp_t;
  exp_t q[$];

  int hi_run = 0;
  int last_run = 0;

  always @(negedge i_clk) begin
    exp_t e;
    chk("sclk_only_with_csb", {31'd0, (o_tex_sclk & o_tex_csb)}, 32'd0);
    chk("oeb_only_with_csb", {31'd0, (~o_tex_oeb & o_tex_csb)}, 32'd0);
    if (o_tex_csb) hi_run++;
    else begin
      if (hi_run > 0) last_run = hi_run;
      hi_run = 0;
    end
    if (o_data_valid) begin
      chk("valid_expected", {31'd0, (q.size() != 0)}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("data", {24'd0, o_data}, {24'd0, e.dat});
        chk("valid_cycle", cyc, e.vcyc);
        chk("csb_at_valid", {31'd0, o_tex_csb}, 32'd1);
        if (!e.hit) begin
          chk("flash_cmd", {24'd0, fcmd}, 32'h6B);
          chk("flash_addr", {8'd0, faddr}, {8'd0, e.addr});
          chk("sclk_rises", rises, 42);
        end else begin
          chk("hit_no_csb_toggle", csb_falls, e.falls);
        end
      end
    end
  end

  // Called at a negedge; returns the index of the accepting clock edge.
  task automatic do_req(input logic [23:0] a, input logic [7:0] d, input bit hit,
                        input bit hold, output int e_edge);
    exp_t e;
    int n;
    n = 0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    while (!o_req_ready && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    chk("ready_wait", {31'd0, (n < 300)}, 32'd1);
    e_edge  = cyc + 1;
    e.dat   = d;
    e.vcyc  = hit ? e_edge : e_edge + LAT;
    e.addr  = a;
    e.hit   = hit;
    e.falls = csb_falls;
    q.push_back(e);
    @(posedge i_clk);
    @(negedge i_clk);
    if (!hold) begin
      i_req_valid = 1'b0;
      i_req_addr  = ~a;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    chk("drain", q.size(), 32'd0);
    @(negedge i_clk);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge i_clk);
  endtask

  initial begin
    int e0, e1, e2;

    // Reset held three cycles
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk("rst_csb", {31'd0, o_tex_csb}, 32'd1);
    chk("rst_sclk", {31'd0, o_tex_sclk}, 32'd0);
    chk("rst_oeb", {31'd0, o_tex_oeb}, 32'd1);
    chk("rst_out0", {31'd0, o_tex_out0}, 32'd0);
    chk("rst_ready", {31'd0, o_req_ready}, 32'd1);
    chk("rst_valid", {31'd0, o_data_valid}, 32'd0);
    chk("rst_data", {24'd0, o_data}, 32'd0);
    i_reset = 1'b0;
    @(negedge i_clk);
    chk("idle_csb", {31'd0, o_tex_csb}, 32'd1);
    chk("idle_ready", {31'd0, o_req_ready}, 32'd1);

    // Single fetch
    do_req(24'h012345, 8'hA5, 1'b0, 1'b0, e0);
    chk("csb_low_after_accept", {31'd0, o_tex_csb}, 32'd0);
    chk("ready_low_after_accept", {31'd0, o_req_ready}, 32'd0);
    wait_until(e0 + LAT + 1);
    chk("ready_back", {31'd0, o_req_ready}, 32'd1);
    drain();

    // Back-to-back with valid held
    do_req(24'h000010, 8'h3C, 1'b0, 1'b1, e1);
    i_req_addr = 24'h000011;
    do_req(24'h000011, 8'hC3, 1'b0, 1'b0, e2);
    chk("b2b_accept_edge", e2, e1 + LAT + 2);
    chk("b2b_csb_low", {31'd0, o_tex_csb}, 32'd0);
    @(negedge i_clk);
    // csb is high in the DONE cycle and in the IDLE cycle that accepts the next request
    chk("b2b_csb_gap", last_run, 32'd2);
    drain();

    // Reset in the middle of the address phase
    do_req(24'h000200, 8'h00, 1'b0, 1'b0, e0);
    wait_until(e0 + 38);
    i_reset = 1'b1;
    q.delete();
    @(negedge i_clk);
    chk("abort_csb", {31'd0, o_tex_csb}, 32'd1);
    chk("abort_sclk", {31'd0, o_tex_sclk}, 32'd0);
    chk("abort_oeb", {31'd0, o_tex_oeb}, 32'd1);
    chk("abort_valid", {31'd0, o_data_valid}, 32'd0);
    chk("abort_ready", {31'd0, o_req_ready}, 32'd1);
    chk("abort_data", {24'd0, o_data}, 32'd0);
    i_reset = 1'b0;
    repeat (100) @(negedge i_clk);
    do_req(24'h000201, 8'hE1, 1'b0, 1'b0, e0);
    drain();

    // Request pulsed during DATA is ignored
    do_req(24'h000300, 8'h7E, 1'b0, 1'b0, e0);
    while (cyc <= e0 + LAT) begin
      chk("busy_ready_low", {31'd0, o_req_ready}, 32'd0);
      if (cyc == e0 + 81) begin
        i_req_valid = 1'b1;
        i_req_addr  = 24'h000400;
      end
      if (cyc == e0 + 82) i_req_valid = 1'b0;
      @(negedge i_clk);
    end
    chk("ignored_ready_back", {31'd0, o_req_ready}, 32'd1);
    drain();
    chk("no_extra_transfer", {31'd0, o_tex_csb}, 32'd1);

`ifdef TEX_SPI_BYTE_CACHE_EN
    do_req(24'h00ABCD, 8'h5A, 1'b0, 1'b0, e0);
    drain();
    do_req(24'h00ABCD, 8'h5A, 1'b1, 1'b0, e0);
    chk("hit_csb_high", {31'd0, o_tex_csb}, 32'd1);
    @(negedge i_clk);
    chk("hit_ready_back", {31'd0, o_req_ready}, 32'd1);
    drain();
    do_req(24'h00ABCE, 8'h96, 1'b0, 1'b0, e0);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
